// File: rtl/grn_node_lut.sv
// grn_node_lut: one gene of a Boolean-network accelerator.
// It tracks a slow (s0) and a fast (s1) trajectory for tortoise/hare
// attractor detection. The next state comes from a run-time loadable truth
// table over NUM_IN regulator inputs. The node also counts s1 flips with a
// saturating counter.
module grn_node_lut #(
    parameter int unsigned NUM_IN   = 3,
    parameter int unsigned SLOW_DIV = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reset_nos,
    input  logic                     init_state,
    input  logic                     lut_we,
    input  logic [(1<<NUM_IN)-1:0]   lut_data,
    input  logic                     start_s0,
    input  logic                     start_s1,
    input  logic [NUM_IN-1:0]        in_s0,
    input  logic [NUM_IN-1:0]        in_s1,
    output logic                     s0,
    output logic                     s1,
    output logic                     match,
    output logic [CNT_W-1:0]         flip_cnt,
    output logic                     flip_sat
);

    localparam int unsigned LUT_W  = 1 << NUM_IN;
    localparam int unsigned PASS_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    // Phase value at which the next start_s0 actually advances s0.
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(SLOW_DIV - 1);

    logic [LUT_W-1:0]  lut_q,  lut_d;
    logic              s0_q,   s0_d;
    logic              s1_q,   s1_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0]  flip_q, flip_d;

    logic lut_s0_val;
    logic lut_s1_val;
    logic flip_full;

    // Truth-table lookups use the table registered before this edge, so a
    // step coinciding with lut_we still sees the old table.
    always_comb begin
        lut_s0_val = lut_q[in_s0];
        lut_s1_val = lut_q[in_s1];
        flip_full  = (flip_q == {CNT_W{1'b1}});
    end

    // Next-state selection for the table, both trajectories and the counters.
    always_comb begin
        lut_d  = lut_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        pass_d = pass_q;
        flip_d = flip_q;

        if (lut_we) begin
            lut_d = lut_data;
        end

        if (reset_nos) begin
            // Presetting the phase makes the very first start_s0 update s0.
            s0_d   = init_state;
            s1_d   = init_state;
            pass_d = PASS_LAST;
            flip_d = '0;
        end else begin
            if (start_s0) begin
                if (pass_q == PASS_LAST) begin
                    s0_d   = lut_s0_val;
                    pass_d = '0;
                end else begin
                    pass_d = pass_q + 1'b1;
                end
            end
            if (start_s1) begin
                s1_d = lut_s1_val;
                if ((lut_s1_val != s1_q) && !flip_full) begin
                    flip_d = flip_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_q  <= '0;
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            pass_q <= '0;
            flip_q <= '0;
        end else begin
            lut_q  <= lut_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            pass_q <= pass_d;
            flip_q <= flip_d;
        end
    end

    // Outputs derived directly from the registers.
    always_comb begin
        s0       = s0_q;
        s1       = s1_q;
        match    = ~(s0_q ^ s1_q);
        flip_cnt = flip_q;
        flip_sat = flip_full;
    end

endmodule
